// File: rtl/yv_pkg.sv
// Shared types and constants for the Y/V column-info encoder.
// Build option: YV_ENC_ROWTAG_EN (read only by yv_word_fmt).
package yv_pkg;

   localparam int unsigned YV_COL_W   = 11;
   localparam int unsigned YV_ROW_W   = 11;
   localparam int unsigned YV_WORD_W  = 16;
   localparam int unsigned YV_LANES   = 4;
   localparam int unsigned YV_SLOT_W  = 3;

   // Column field split: [1:0] V bank, [10:2] bank address
   localparam int unsigned YV_BANK_LSB = 0;
   localparam int unsigned YV_BANK_MSB = 1;
   localparam int unsigned YV_ADDR_LSB = 2;
   localparam int unsigned YV_ADDR_MSB = 10;

   localparam logic [2:0] YV_TAG_ENTRY = 3'b000;
   localparam logic [2:0] YV_TAG_MARK  = 3'b111;
   localparam logic [YV_WORD_W-1:0] YV_MARK = 16'hE000;

   typedef logic [YV_WORD_W-1:0] yv_word_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT,
      DONE
   } yv_state_e;

   typedef struct packed {
      logic [YV_ROW_W-1:0] row;
      logic [YV_COL_W-1:0] col;
      logic                last;
   } yv_entry_t;

endpackage

// File: rtl/yv_col_encoder_if.sv
// Entry stream in, row beats out, between the loader and the y_col_info FIFOs.
interface yv_col_encoder_if;
   import yv_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [YV_ROW_W-1:0] in_row;
   logic [YV_COL_W-1:0] in_col;
   logic                in_last;

   logic     out_valid;
   logic     out_ready;
   yv_word_t y_1_col_info;
   yv_word_t y_2_col_info;
   yv_word_t y_3_col_info;
   yv_word_t y_4_col_info;

   modport master (
      output in_valid, in_row, in_col, in_last, out_ready,
      input  in_ready, out_valid,
      input  y_1_col_info, y_2_col_info, y_3_col_info, y_4_col_info
   );

   modport slave (
      input  in_valid, in_row, in_col, in_last, out_ready,
      output in_ready, out_valid,
      output y_1_col_info, y_2_col_info, y_3_col_info, y_4_col_info
   );

endinterface

// File: rtl/yv_word_fmt.sv
// Formats one lane word: column entry or new-row marker.
// YV_ENC_ROWTAG_EN: markers carry the row number in [10:0].
module yv_word_fmt
   import yv_pkg::*;
(
   input  logic [YV_COL_W-1:0] col,
   input  logic [YV_ROW_W-1:0] row,
   input  logic                is_mark,
   output yv_word_t            word_c
);

   yv_word_t mark_word;

`ifdef YV_ENC_ROWTAG_EN
   assign mark_word = {YV_TAG_MARK, 2'b00, row};
`else
   logic unused_row;
   assign unused_row = ^row;
   assign mark_word  = YV_MARK;
`endif

   assign word_c = is_mark ? mark_word
                           : {YV_TAG_ENTRY, 2'b00,
                              col[YV_ADDR_MSB:YV_ADDR_LSB],
                              col[YV_BANK_MSB:YV_BANK_LSB]};

endmodule

// File: rtl/yv_col_encoder.sv
// Packs row-ordered nonzero coordinates into one 4-lane beat per matrix row,
// padding empty lanes and skipped rows with markers. Option: YV_ENC_ROWTAG_EN.
module yv_col_encoder
   import yv_pkg::*;
#(
   parameter logic [YV_ROW_W-1:0] ROW_BASE = 11'd63,
   parameter int unsigned         LANES    = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   yv_col_encoder_if.slave bus,
   output logic            overflow,
   output logic            order_err,
   output logic            done
);

   typedef logic [YV_LANES-1:0][YV_WORD_W-1:0] lanes_t;

   localparam logic [YV_SLOT_W-1:0] SLOT_FULL = YV_SLOT_W'(LANES);

   yv_state_e            state_q, state_d;
   logic [YV_ROW_W-1:0]  cur_row_q, cur_row_d;
   logic [YV_SLOT_W-1:0] slot_q, slot_d;
   lanes_t               lane_q, lane_d;
   yv_entry_t            pend_q, pend_d;
   logic                 pend_v_q, pend_v_d;
   logic                 last_q, last_d;
   logic                 overflow_d, order_err_d;
   logic                 out_valid_q;

   logic [YV_ROW_W-1:0]  row_inc_c;
   logic [YV_ROW_W-1:0]  mark_row_c;
   yv_word_t             in_word_c, pend_word_c, mark_word_c;

   assign row_inc_c  = YV_ROW_W'(cur_row_q + 1'b1);
   // Markers are only needed on start (first row) or when a beat retires (next row)
   assign mark_row_c = (state_q == EMIT) ? row_inc_c : ROW_BASE;

   yv_word_fmt u_fmt_in (
      .col     (bus.in_col),
      .row     (cur_row_q),
      .is_mark (1'b0),
      .word_c  (in_word_c)
   );

   yv_word_fmt u_fmt_pend (
      .col     (pend_q.col),
      .row     (pend_q.row),
      .is_mark (1'b0),
      .word_c  (pend_word_c)
   );

   yv_word_fmt u_fmt_mark (
      .col     ('0),
      .row     (mark_row_c),
      .is_mark (1'b1),
      .word_c  (mark_word_c)
   );

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      cur_row_d   = cur_row_q;
      slot_d      = slot_q;
      lane_d      = lane_q;
      pend_d      = pend_q;
      pend_v_d    = pend_v_q;
      last_d      = last_q;
      overflow_d  = overflow;
      order_err_d = order_err;

      if (!enable) begin
         state_d  = IDLE;
         slot_d   = '0;
         lane_d   = {YV_LANES{YV_MARK}};
         pend_v_d = 1'b0;
         last_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = COLLECT;
               cur_row_d   = ROW_BASE;
               slot_d      = '0;
               lane_d      = {YV_LANES{mark_word_c}};
               pend_v_d    = 1'b0;
               last_d      = 1'b0;
               overflow_d  = 1'b0;
               order_err_d = 1'b0;
            end

            COLLECT: begin
               if (bus.in_valid) begin
                  if (bus.in_row > cur_row_q) begin
                     pend_d.row  = bus.in_row;
                     pend_d.col  = bus.in_col;
                     pend_d.last = bus.in_last;
                     pend_v_d    = 1'b1;
                     state_d     = EMIT;
                  end else begin
                     if (bus.in_row < cur_row_q) begin
                        order_err_d = 1'b1;
                     end else if (slot_q < SLOT_FULL) begin
                        lane_d[slot_q[1:0]] = in_word_c;
                        slot_d              = YV_SLOT_W'(slot_q + 1'b1);
                     end else begin
                        overflow_d = 1'b1;
                     end
                     // Dropped entries still close the matrix
                     if (bus.in_last) begin
                        last_d  = 1'b1;
                        state_d = EMIT;
                     end
                  end
               end
            end

            EMIT: begin
               if (bus.out_ready) begin
                  cur_row_d = row_inc_c;
                  slot_d    = '0;
                  lane_d    = {YV_LANES{mark_word_c}};
                  if (pend_v_q && (pend_q.row > row_inc_c)) begin
                     state_d = EMIT;
                  end else if (pend_v_q) begin
                     lane_d[0] = pend_word_c;
                     slot_d    = YV_SLOT_W'(1);
                     pend_v_d  = 1'b0;
                     if (pend_q.last) begin
                        last_d  = 1'b1;
                        state_d = EMIT;
                     end else begin
                        state_d = COLLECT;
                     end
                  end else if (last_q) begin
                     state_d = DONE;
                  end else begin
                     state_d = COLLECT;
                  end
               end
            end

            DONE: begin
               state_d = DONE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cur_row_q   <= ROW_BASE;
         slot_q      <= '0;
         lane_q      <= {YV_LANES{YV_MARK}};
         pend_q      <= '0;
         pend_v_q    <= 1'b0;
         last_q      <= 1'b0;
         overflow    <= 1'b0;
         order_err   <= 1'b0;
         out_valid_q <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_row_q   <= cur_row_d;
         slot_q      <= slot_d;
         lane_q      <= lane_d;
         pend_q      <= pend_d;
         pend_v_q    <= pend_v_d;
         last_q      <= last_d;
         overflow    <= overflow_d;
         order_err   <= order_err_d;
         out_valid_q <= (state_d == EMIT);
         done        <= (state_d == DONE);
      end
   end

   // in_ready decodes the state register so the entry path has no input-to-output loop
   assign bus.in_ready     = (state_q == COLLECT);
   assign bus.out_valid    = out_valid_q;
   assign bus.y_1_col_info = lane_q[0];
   assign bus.y_2_col_info = lane_q[1];
   assign bus.y_3_col_info = lane_q[2];
   assign bus.y_4_col_info = lane_q[3];

endmodule

// File: tb/tb_yv_col_encoder.sv
// Self-checking bench for yv_col_encoder: entry tables drive the input, a beat
// scoreboard checks the output. Honors YV_ENC_ROWTAG_EN for expected markers.
module tb_yv_col_encoder;

   typedef struct {
      logic [10:0] row;
      logic [10:0] col;
      logic        last;
   } vec_t;

   logic clock;
   logic reset;
   logic enable;
   logic overflow;
   logic order_err;
   logic done;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t        stim[$];
   logic [63:0] exp_q[$];

   yv_col_encoder_if bus ();

   yv_col_encoder dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .bus       (bus),
      .overflow  (overflow),
      .order_err (order_err),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] mk(input logic [10:0] r);
      logic [15:0] m;
      m = {3'b111, 2'b00, r};
`ifndef YV_ENC_ROWTAG_EN
      m[10:0] = 11'd0;
`endif
      return m;
   endfunction

   function automatic logic [15:0] ent(input logic [10:0] c);
      return {5'b00000, c};
   endfunction

   function automatic logic [63:0] lanes();
      return {bus.y_1_col_info, bus.y_2_col_info, bus.y_3_col_info, bus.y_4_col_info};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [10:0] r, input logic [10:0] c, input logic l);
      vec_t v;
      v.row  = r;
      v.col  = c;
      v.last = l;
      stim.push_back(v);
   endtask

   task automatic expb(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
      exp_q.push_back({a, b, c, d});
   endtask

   task automatic send(input vec_t v);
      int n;
      bus.in_valid = 1'b1;
      bus.in_row   = v.row;
      bus.in_col   = v.col;
      bus.in_last  = v.last;
      n = 0;
      @(negedge clock);
      while (!bus.in_ready && n < 200) begin
         n++;
         @(negedge clock);
      end
      if (!bus.in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: row %0d col %0d never accepted", v.row, v.col);
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_stim();
      for (int i = 0; i < stim.size(); i++) begin
         send(stim[i]);
      end
      stim.delete();
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         n++;
         @(negedge clock);
      end
      check("done", 64'(done), 64'd1);
      check("beats_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic restart();
      enable = 1'b0;
      @(posedge clock);
      #1;
      enable = 1'b1;
   endtask

   // Scoreboard: compare each beat the instant it is handed over
   always @(negedge clock) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_unexpected: got %h, expected no beat", lanes());
         end else begin
            check("beat", lanes(), exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      enable        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_row    = '0;
      bus.in_col    = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_flags", {61'd0, overflow, order_err, done}, 64'd0);
      check("rst_lanes", lanes(), {4{16'hE000}});
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Two rows, last entry on a row change
      @(posedge clock);
      #1;
      enable = 1'b1;
      expb(ent(11'd5), ent(11'd6), mk(11'd63), mk(11'd63));
      expb(ent(11'd9), mk(11'd64), mk(11'd64), mk(11'd64));
      add(11'd63, 11'd5, 1'b0);
      add(11'd63, 11'd6, 1'b0);
      add(11'd64, 11'd9, 1'b1);
      run_stim();
      wait_done();
      check("a_in_ready_done", 64'(bus.in_ready), 64'd0);
      enable = 1'b0;
      @(posedge clock);
      #1;
      check("a_idle_done", 64'(done), 64'd0);

      // Row gap: two all-marker beats for skipped rows
      enable = 1'b1;
      expb(ent(11'd1), mk(11'd63), mk(11'd63), mk(11'd63));
      expb(mk(11'd64), mk(11'd64), mk(11'd64), mk(11'd64));
      expb(mk(11'd65), mk(11'd65), mk(11'd65), mk(11'd65));
      expb(ent(11'd2), mk(11'd66), mk(11'd66), mk(11'd66));
      add(11'd63, 11'd1, 1'b0);
      add(11'd66, 11'd2, 1'b1);
      run_stim();
      wait_done();
      check("b_overflow", 64'(overflow), 64'd0);

      // Six entries in one row: extra two dropped
      restart();
      expb(ent(11'd10), ent(11'd11), ent(11'd12), ent(11'd13));
      expb(ent(11'd20), mk(11'd64), mk(11'd64), mk(11'd64));
      for (int i = 0; i < 6; i++) add(11'd63, 11'(10 + i), 1'b0);
      add(11'd64, 11'd20, 1'b1);
      run_stim();
      wait_done();
      check("c_overflow", 64'(overflow), 64'd1);
      check("c_order_err", 64'(order_err), 64'd0);

      // Backpressure: beat held for five cycles
      restart();
      bus.out_ready = 1'b0;
      expb(ent(11'd7), mk(11'd63), mk(11'd63), mk(11'd63));
      expb(ent(11'd8), mk(11'd64), mk(11'd64), mk(11'd64));
      add(11'd63, 11'd7, 1'b0);
      add(11'd64, 11'd8, 1'b1);
      run_stim();
      check("d_latency_valid", 64'(bus.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("d_hold_lanes", lanes(), {ent(11'd7), mk(11'd63), mk(11'd63), mk(11'd63)});
         check("d_hold_in_ready", 64'(bus.in_ready), 64'd0);
         check("d_hold_valid", 64'(bus.out_valid), 64'd1);
      end
      @(posedge clock);
      #1;
      bus.out_ready = 1'b1;
      wait_done();

      // Row decrease dropped, then enable removed mid-collect
      restart();
      for (int r = 63; r < 70; r++) begin
         expb(mk(11'(r)), mk(11'(r)), mk(11'(r)), mk(11'(r)));
      end
      add(11'd70, 11'd3, 1'b0);
      add(11'd68, 11'd4, 1'b0);
      run_stim();
      @(negedge clock);
      check("e_order_err", 64'(order_err), 64'd1);
      check("e_in_ready", 64'(bus.in_ready), 64'd1);
      check("e_lane1", 64'(bus.y_1_col_info), 64'(ent(11'd3)));
      check("e_beats_left", 64'(exp_q.size()), 64'd0);
      @(posedge clock);
      #1;
      enable = 1'b0;
      @(posedge clock);
      #1;
      check("e_idle_in_ready", 64'(bus.in_ready), 64'd0);
      check("e_idle_valid", 64'(bus.out_valid), 64'd0);
      check("e_idle_lanes", lanes(), {4{16'hE000}});
      check("e_sticky_held", 64'(order_err), 64'd1);
      enable = 1'b1;
      @(posedge clock);
      #1;
      check("e_restart_clear", 64'(order_err), 64'd0);
      check("e_restart_ready", 64'(bus.in_ready), 64'd1);
      enable = 1'b0;
      repeat (2) @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/yv_col_encoder.md
# yv_col_encoder

Packs a row-ordered stream of sparse-matrix nonzero coordinates into the four 16-bit `y_*_col_info` words consumed by the Y/V fetch controller. Each output beat is exactly one matrix row, up to four column entries per beat. Empty lanes and skipped rows are filled with new-row marker words, so the downstream row counter stays aligned. The block sits between the matrix-loading front end and the y_col_info FIFOs, acting as the transmitter for the fetch controller's receiver.

## Interface
Parameters:
- `ROW_BASE`, default 11'd63: row index of the first emitted beat; matches the fetch controller's starting row.
- `LANES`, default 4: entries per beat; fixed at 4, kept for readability only.

Ports:
- `clock`  in  1: single clock; all logic is posedge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: run. Low returns the block to IDLE synchronously.
- `in_valid`  in  1: input entry valid.
- `in_ready`  out  1: block accepts the entry when `in_valid & in_ready`.
- `in_row`  in  11: row index of the entry; must be nondecreasing.
- `in_col`  in  11: column index. [1:0] is the V bank, [10:2] is the bank address.
- `in_last`  in  1: marks the final entry of the matrix.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: downstream (FIFO not full) accepts the beat.
- `y_1_col_info` … `y_4_col_info`  out  16: lane words.
- `overflow`  out  1: sticky; set when a row had more than 4 entries.
- `order_err`  out  1: sticky; set when `in_row` is below the current row.
- `done`  out  1: high after the final beat has been accepted.

## Operation
- Entry word: {3'b000, 2'b00, in_col[10:0]}.
- Marker word (MARK): 16'hE000, i.e. [15:13]=3'b111.
- Registers:
  - `cur_row` (11b)
  - `slot` (0..4)
  - four lane registers
  - pending entry {`pend_row`, `pend_col`, `pend_last`} plus `pend_v`
- IDLE: `in_ready`=0, `out_valid`=0, lanes=MARK.
  - `enable`=1 → COLLECT, `cur_row`=ROW_BASE, `slot`=0, sticky flags cleared.
- COLLECT: `in_ready`=1. On accept:
  - `in_row`==`cur_row`, `slot`<4: lane[`slot`]←entry, `slot`++. If `in_last`, set a last flag and go to EMIT.
  - `in_row`==`cur_row`, `slot`==4: drop the entry and set `overflow`. `in_last` is still honoured.
  - `in_row`>`cur_row`: store in pending, go to EMIT.
  - `in_row`<`cur_row`: drop the entry and set `order_err`. `in_last` is still honoured.
- EMIT: `out_valid`=1 with the lanes held stable. On `out_ready`:
  - `cur_row`++, `slot`=0, lanes=MARK.
  - If `pend_v` and `pend_row`>`cur_row`+1: stay in EMIT (gap beat, all MARK).
  - Else if `pend_v`: lane1←pend, `slot`=1, `pend_v`=0. If `pend_last`, stay in EMIT; otherwise go to COLLECT.
  - Else if the last flag is set: go to DONE.
  - Else: go to COLLECT.
- DONE: `done`=1, `in_ready`=0. `enable`=0 → IDLE.
- `enable`=0 in any state: next cycle IDLE. Lanes and pending are discarded; sticky flags are held until the next start.
- `cur_row` wraps modulo 2^11; no wrap detection.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `overflow`=0, `order_err`=0, `done`=0
  - all `y_*_col_info`=16'hE000
  - state IDLE
- All outputs are registered except `in_ready`, which is decoded from the state register only.
- Row-change entry accepted at cycle N → `out_valid` at N+1.
- Each gap beat costs one cycle when `out_ready`=1.
- Lane words never change while `out_valid`=1 and `out_ready`=0.
- `in_ready` is 0 throughout EMIT, so at most one entry is held in pending at any time.

## Configuration
- `YV_ENC_ROWTAG_EN` defined: marker words carry the row, {3'b111, 2'b00, `cur_row`}.
  - Padding lanes carry the emitted row.
  - Gap beats carry the skipped row number.
  - Downstream decoding is unaffected because it checks only [15:13].
- Undefined: markers are constant 16'hE000.

## Structure
- Shared package `yv_pkg`:
  - `YV_MARK`=16'hE000
  - `YV_COL_W`=11, `YV_WORD_W`=16
  - bank/address field positions
  - state enum {IDLE, COLLECT, EMIT, DONE}
- Sub-module `yv_word_fmt`: combinational entry/marker formatter (col, row, is_mark → 16b word), and the only place `YV_ENC_ROWTAG_EN` is read.

## Test plan
- Start, rows 63: cols {5,6}, row 64: col {9}, last → beat1 {0x0005, 0x0006, E000, E000}; beat2 {0x0009, E000, E000, E000}; `done`=1.
- Row 63: col 1, then row 66: col 2 (last) → beats: {0x0001, MARK×3}; two all-MARK gap beats for rows 64–65; {0x0002, MARK×3}.
- Row 63 with 6 entries → first 4 emitted in order, `overflow`=1, next beat unaffected.
- `out_ready` held low 5 cycles during EMIT → lanes stable, `in_ready`=0, no entry lost.
- Row 70 then row 68 → row-68 entry dropped, `order_err`=1. Then drop `enable` mid-COLLECT → IDLE next cycle, lanes=E000.
- With `YV_ENC_ROWTAG_EN`: the gap beat for row 64 → all lanes 0xE040.
